// File: rtl/irq_prio_encoder.sv
// Registered N-source request encoder: pending capture, per-source mask, fixed or
// round-robin selection, presented on a valid/ready output with a binary and one-hot code.
module irq_prio_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter bit RR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic             clr_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_code,
    output logic [N-1:0]     out_onehot,
    output logic [N-1:0]     pend_o,
    output logic             overflow_o
);

    logic [N-1:0]     pend_q, pend_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [N-1:0]     elig;
    logic [N-1:0]     sel_oh;
    logic [N-1:0]     taken;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cidx;
    logic             found;
    logic             load;
    int               cand;

    assign elig = (pend_q | req_i) & mask_i;
    assign load = !valid_q || out_ready;

    // Round-robin search wraps modulo N, so codes >= N are never visited.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        if (!RR) begin
            for (int i = 0; i < N; i++) begin
                cidx = IDX_W'(i);
                if (!found && elig[cidx]) begin
                    found        = 1'b1;
                    sel_idx      = cidx;
                    sel_oh[cidx] = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(ptr_q) + k) % N;
                cidx = IDX_W'(cand);
                if (!found && elig[cidx]) begin
                    found        = 1'b1;
                    sel_idx      = cidx;
                    sel_oh[cidx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        taken    = load ? sel_oh : '0;
        pend_d   = (pend_q | req_i) & ~taken;
        ovf_d    = |(req_i & pend_q & ~taken);
        valid_d  = valid_q;
        code_d   = code_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        if (load) begin
            valid_d  = found;
            code_d   = sel_idx;
            onehot_d = sel_oh;
            if (found) begin
                ptr_d = sel_idx;
            end
        end
        // Flush wins over any same-cycle request or load; the RR pointer survives it.
        if (clr_i) begin
            pend_d   = '0;
            ovf_d    = 1'b0;
            valid_d  = 1'b0;
            code_d   = '0;
            onehot_d = '0;
            ptr_d    = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            onehot_q <= '0;
            code_q   <= '0;
            ptr_q    <= IDX_W'(N - 1);
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            onehot_q <= onehot_d;
            code_q   <= code_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_code   = code_q;
    assign out_onehot = onehot_q;
    assign pend_o     = pend_q;
    assign overflow_o = ovf_q;

endmodule
